// File: rtl/switch_pkg.sv
// Shared definitions for the switch egress path: packet header offsets,
// port address type, egress FSM states and a saturating increment helper.
package switch_pkg;

  // Byte offsets of the header fields inside a packet.
  localparam int PKT_DA  = 0;
  localparam int PKT_SA  = 1;
  localparam int PKT_LEN = 2;

  typedef logic [1:0] port_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } out_state_e;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    if (v >= max_v)
      return max_v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/switch_pkt_fifo.sv
// Packet byte buffer for one egress port. Each entry holds {last, byte}.
// Writes advance a speculative pointer; commit publishes the packet to the
// reader, rewind throws the partial packet away. The read byte is registered.
module switch_pkt_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [8:0]               push_data,
  input  logic                     commit,
  input  logic                     rewind,
  input  logic                     pop,
  output logic [7:0]               rd_byte,
  output logic                     head_last,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] cmt_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [7:0]    rd_byte_reg;

  // Storage write; the array carries no reset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Pointer bookkeeping and registered read of the popped entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      cmt_ptr_reg <= '0;
      rd_ptr_reg  <= '0;
      rd_byte_reg <= '0;
    end else begin
      if (rewind)
        wr_ptr_reg <= cmt_ptr_reg;
      else if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      // Commit always accompanies the push of the last byte.
      if (commit)
        cmt_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PW'(1);
        rd_byte_reg <= mem[rd_ptr_reg[AW-1:0]][7:0];
      end
    end
  end

  // Space is counted against the speculative pointer so a packet being
  // written cannot overrun unread data; a popped entry frees up next cycle.
  assign free      = PW'(DEPTH) - (wr_ptr_reg - rd_ptr_reg);
  assign empty     = (rd_ptr_reg == cmt_ptr_reg);
  assign head_last = mem[rd_ptr_reg[AW-1:0]][8];
  assign rd_byte   = rd_byte_reg;

endmodule

// File: rtl/switch_out_port.sv
// Switch egress port: accepts whole packets from the switch core, drops
// packets that do not fit (and, with SWITCH_PARITY_CHK_EN defined, packets
// whose running XOR is nonzero), and serves committed packets to the reader
// over the data_out/ready/read handshake with one idle GAP cycle between them.
module switch_out_port
  import switch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             wr_last,
  output logic [7:0]       data_out,
  output logic             ready,
  input  logic             read,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PW = $clog2(DEPTH) + 1;

  out_state_e       state_reg, state_next;
  logic [PW-1:0]    pkt_cnt_reg, pkt_cnt_next;
  logic             drop_flag_reg, drop_flag_next;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic [PW-1:0]    free;
  logic             empty;
  logic             head_last;
  logic             wr_take, overflow, push, par_bad, commit, rewind, drop_done;
  logic             pop, last_pop;

  // Write side: bytes are ignored while a packet is being discarded.
  assign wr_take   = wr_en && !drop_flag_reg;
  assign overflow  = wr_take && (free == '0);
  assign push      = wr_take && (free != '0);
  assign commit    = push && wr_last && !par_bad;
  assign rewind    = overflow || par_bad;
  assign drop_done = wr_en && wr_last && (drop_flag_reg || overflow);

`ifdef SWITCH_PARITY_CHK_EN
  logic [7:0]       par_reg, par_next;
  logic [CNT_W-1:0] err_cnt_reg;

  // A packet whose bytes (parity byte included) XOR to nonzero is bad.
  assign par_bad = push && wr_last && ((par_reg ^ wr_data) != 8'h00);

  // Running XOR restarts at every packet boundary and after an overflow.
  always_comb begin
    par_next = par_reg;
    if (push)
      par_next = wr_last ? 8'h00 : (par_reg ^ wr_data);
    if (overflow)
      par_next = 8'h00;
  end

  // Parity state and error counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_reg     <= 8'h00;
      err_cnt_reg <= '0;
    end else begin
      par_reg <= par_next;
      if (par_bad)
        err_cnt_reg <= CNT_W'(sat_inc(32'(err_cnt_reg), CNT_W));
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign par_bad = 1'b0;
  assign err_cnt = '0;
`endif

  // Read side: pops only happen while presenting a packet.
  assign pop      = (state_reg == SEND) && read && !empty;
  assign last_pop = pop && head_last;

  switch_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_last, wr_data}),
    .commit    (commit),
    .rewind    (rewind),
    .pop       (pop),
    .rd_byte   (data_out),
    .head_last (head_last),
    .empty     (empty),
    .free      (free)
  );

  // Next-state for the egress FSM, the packet count and the drop flag.
  always_comb begin
    state_next     = state_reg;
    pkt_cnt_next   = pkt_cnt_reg;
    drop_flag_next = drop_flag_reg;
    case (state_reg)
      IDLE:    if (pkt_cnt_reg != '0) state_next = SEND;
      SEND:    if (last_pop) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    case ({commit, last_pop})
      2'b10:   pkt_cnt_next = pkt_cnt_reg + PW'(1);
      2'b01:   pkt_cnt_next = pkt_cnt_reg - PW'(1);
      default: pkt_cnt_next = pkt_cnt_reg;
    endcase
    if (drop_done)
      drop_flag_next = 1'b0;
    else if (overflow)
      drop_flag_next = 1'b1;
  end

  // State registers and the overflow drop counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pkt_cnt_reg   <= '0;
      drop_flag_reg <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pkt_cnt_reg   <= pkt_cnt_next;
      drop_flag_reg <= drop_flag_next;
      if (drop_done)
        drop_cnt_reg <= CNT_W'(sat_inc(32'(drop_cnt_reg), CNT_W));
    end
  end

  assign ready    = (state_reg == SEND);
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_switch_out_port.sv
// Bench for switch_out_port (DEPTH=16): a cycle table for the basic packet,
// then hand sequences checked by a byte scoreboard of expected reader output.
module tb_switch_out_port;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       read = 1'b0;
  logic [7:0] data_out;
  logic       ready;
  logic [7:0] drop_cnt;
  logic [7:0] err_cnt;

  switch_out_port #(.DEPTH(16), .CNT_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .data_out (data_out),
    .ready    (ready),
    .read     (read),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clock = ~clock;

`ifdef SWITCH_PARITY_CHK_EN
  localparam logic [7:0] GOOD_LAST = 8'hB8;  // 01^AA^02^11 = B8 -> XOR zero
`else
  localparam logic [7:0] GOOD_LAST = 8'hBB;
`endif

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       last;
    logic       rd;
    logic       exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       tv [13];
  int         total = 0;
  int         bad = 0;
  logic [8:0] exp_q [$];   // {last, byte} the reader should see, in order
  logic [7:0] pkt_q [$];   // packet being written
  logic [7:0] last_exp = 8'h00;
  bit         sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock: drive inputs, take the edge, check outputs 1ns later.
  task automatic cycle(input logic we, input logic [7:0] d, input logic last, input logic rd);
    logic       pop_now;
    logic [8:0] e;
    wr_en = we; wr_data = d; wr_last = last; read = rd;
    pop_now = ready && rd;
    @(posedge clock); #1;
    wr_en = 1'b0; wr_last = 1'b0; read = 1'b0;
    if (sb_en) begin
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pop: got byte %h want no pop", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e[7:0]);
          chk("ready_after_pop", ready, !e[8]);
          last_exp = e[7:0];
        end
      end else begin
        chk("data_hold", data_out, last_exp);
      end
    end
  endtask

  // Write pkt_q as one packet; queue it for the reader if it should commit.
  task automatic send_pkt(input bit expect_ok, input logic rd);
    int n;
    n = pkt_q.size();
    if (expect_ok)
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, pkt_q[i]});
    for (int i = 0; i < n; i++) cycle(1'b1, pkt_q[i], i == n - 1, rd);
  endtask

  // Parity-consistent packet: last byte is the XOR of the others.
  task automatic make_pkt(input logic [7:0] base, input int n);
    logic [7:0] x;
    x = 8'h00;
    pkt_q.delete();
    for (int i = 0; i < n - 1; i++) begin
      pkt_q.push_back(base + 8'(i * 7));
      x = x ^ (base + 8'(i * 7));
    end
    pkt_q.push_back(x);
  endtask

  task automatic make_good();
    pkt_q.delete();
    pkt_q.push_back(8'h01); pkt_q.push_back(8'hAA); pkt_q.push_back(8'h02);
    pkt_q.push_back(8'h11); pkt_q.push_back(GOOD_LAST);
  endtask

  // Read continuously until the scoreboard empties or the budget runs out.
  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles && exp_q.size() != 0; c++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_data", data_out, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err_cnt, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Test 1: 5-byte packet, read held high, cycle-exact table
    tv[0]  = '{1, 8'h01,     0, 0, 0, 8'h00};
    tv[1]  = '{1, 8'hAA,     0, 0, 0, 8'h00};
    tv[2]  = '{1, 8'h02,     0, 0, 0, 8'h00};
    tv[3]  = '{1, 8'h11,     0, 0, 0, 8'h00};
    tv[4]  = '{1, GOOD_LAST, 1, 0, 0, 8'h00};
    tv[5]  = '{0, 8'h00,     0, 1, 1, 8'h00};  // read while IDLE ignored
    tv[6]  = '{0, 8'h00,     0, 1, 1, 8'h01};
    tv[7]  = '{0, 8'h00,     0, 1, 1, 8'hAA};
    tv[8]  = '{0, 8'h00,     0, 1, 1, 8'h02};
    tv[9]  = '{0, 8'h00,     0, 1, 1, 8'h11};
    tv[10] = '{0, 8'h00,     0, 1, 0, GOOD_LAST}; // ready drops with last byte
    tv[11] = '{0, 8'h00,     0, 1, 0, GOOD_LAST}; // GAP: read ignored
    tv[12] = '{0, 8'h00,     0, 1, 0, GOOD_LAST}; // IDLE, nothing queued
    for (int i = 0; i < 13; i++) begin
      cycle(tv[i].we, tv[i].d, tv[i].last, tv[i].rd);
      chk($sformatf("t1_ready[%0d]", i), ready, tv[i].exp_ready);
      chk($sformatf("t1_data[%0d]", i), data_out, tv[i].exp_data);
    end
    last_exp = GOOD_LAST;
    sb_en = 1'b1;

    // Test 2: same packet, read toggled 1,0,1,0...
    make_good();
    send_pkt(1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_ready", ready, 1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00, 1'b0, (k % 2) == 0);
    chk("t2_left", exp_q.size(), 0);

    // Test 3: fill to 16/16, then a 20-byte packet is dropped
    for (int p = 0; p < 3; p++) begin
      make_pkt(8'h10 + 8'(p * 16), 5);
      send_pkt(1'b1, 1'b0);
    end
    pkt_q.delete(); pkt_q.push_back(8'h00);
    send_pkt(1'b1, 1'b0);
    make_pkt(8'h40, 20);
    send_pkt(1'b0, 1'b0);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_ready", ready, 1);
    drain(200);

    // Test 4: write packet B while reading packet A
    make_pkt(8'h60, 5);
    send_pkt(1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    make_pkt(8'h80, 6);
    send_pkt(1'b1, 1'b1);
    drain(100);
    chk("t4_drop_cnt", drop_cnt, 1);

    // Test 5: packet whose XOR is nonzero
    pkt_q.delete();
    pkt_q.push_back(8'h01); pkt_q.push_back(8'hAA); pkt_q.push_back(8'h02);
    pkt_q.push_back(8'h11); pkt_q.push_back(8'h00);
`ifdef SWITCH_PARITY_CHK_EN
    send_pkt(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t5_ready_low", ready, 0);
    end
    chk("t5_err_cnt", err_cnt, 1);
`else
    send_pkt(1'b1, 1'b0);
    drain(50);
    chk("t5_err_cnt", err_cnt, 0);
`endif
    make_good();
    send_pkt(1'b1, 1'b0);
    drain(50);

    // Test 6: reset after three bytes of a packet were read
    make_good();
    send_pkt(1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("t6_ready", ready, 0);
    chk("t6_data", data_out, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_err", err_cnt, 0);
    exp_q.delete();
    last_exp = 8'h00;
    @(posedge clock); #1;
    reset = 1'b0;
    make_pkt(8'h33, 4);
    send_pkt(1'b1, 1'b0);
    drain(50);
    chk("t6_drop_after", drop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
